// File: rtl/instr_fetch_issue_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_issue_if : ALU issue channel, program-write bus and status
//                        between the fetch/issue block and its environment
// Revision 1.0
// ============================================================================
interface instr_fetch_issue_if #(
    parameter int width = 4,
    parameter int iw    = 12
);
    logic [width-1:0] pc_addr;
    logic             run;
    logic             prog_we;
    logic [width-1:0] prog_addr;
    logic [iw-1:0]    prog_data;
    logic             alu_ready;
    logic [3:0]       alu_op;
    logic [7:0]       alu_operand;
    logic             op_valid;
    logic             pc_step;
    logic             halted;
    logic [7:0]       issued_cnt;

    // The fetch/issue block is the master of the ALU issue channel.
    modport master (
        input  pc_addr, run, prog_we, prog_addr, prog_data, alu_ready,
        output alu_op, alu_operand, op_valid, pc_step, halted, issued_cnt
    );

    modport slave (
        output pc_addr, run, prog_we, prog_addr, prog_data, alu_ready,
        input  alu_op, alu_operand, op_valid, pc_step, halted, issued_cnt
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_issue.sv
`default_nettype none
// ============================================================================
// instr_fetch_issue : fetches instructions at pc_addr, issues them to the ALU
//                     over valid/ready, and pulses pc_step to advance the PC
// Revision 1.0
// ============================================================================
module instr_fetch_issue #(
    parameter int width = 4,
    parameter int iw    = 12
) (
    input  logic                 count,
    input  logic                 reset,
    instr_fetch_issue_if.master  bus
);

    localparam int         DEPTH   = 2 ** width;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_STEP  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [iw-1:0] instr_q, instr_d;
    logic        op_valid_q, op_valid_d;
    logic        pc_step_q, pc_step_d;
    logic        halted_q, halted_d;
    logic [7:0]  issued_cnt_q, issued_cnt_d;

    logic [iw-1:0] mem [0:DEPTH-1];
    logic [iw-1:0] fetch_word;
    logic [3:0]    fetch_opcode;
    logic          prog_wr_en;
    logic          handshake;

    assign fetch_word   = mem[bus.pc_addr];
    assign fetch_opcode = fetch_word[11:8];
    assign handshake    = op_valid_q && bus.alu_ready;

    // Writes are only safe while nothing is being fetched or issued.
    assign prog_wr_en = bus.prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

    // Program memory survives reset so a program can be re-run after an abort.
    always_ff @(posedge count) begin
        if (prog_wr_en) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        op_valid_d   = op_valid_q;
        pc_step_d    = 1'b0;
        halted_d     = halted_q;
        issued_cnt_d = issued_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = fetch_word;
                if (fetch_opcode == OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (fetch_opcode == OP_NOP) begin
                    state_d   = S_STEP;
                    pc_step_d = 1'b1;
                end else begin
                    state_d    = S_ISSUE;
                    op_valid_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (handshake) begin
                    op_valid_d   = 1'b0;
                    issued_cnt_d = issued_cnt_q + 8'd1;
                    pc_step_d    = 1'b1;
                    state_d      = S_STEP;
                end
            end
            S_STEP: begin
                // run is only sampled here, so a drop mid-instruction still completes it.
                state_d = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                op_valid_d = 1'b0;
                halted_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge count or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            op_valid_q   <= 1'b0;
            pc_step_q    <= 1'b0;
            halted_q     <= 1'b0;
            issued_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            op_valid_q   <= op_valid_d;
            pc_step_q    <= pc_step_d;
            halted_q     <= halted_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign bus.alu_op      = instr_q[11:8];
    assign bus.alu_operand = instr_q[7:0];
    assign bus.op_valid    = op_valid_q;
    assign bus.pc_step     = pc_step_q;
    assign bus.halted      = halted_q;
    assign bus.issued_cnt  = issued_cnt_q;

endmodule
`default_nettype wire

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Sits directly downstream of the program counter, which advances by its offset on each rising edge of its count input.
- Holds a small program memory addressed by the counter's output and fetches the instruction at that address.
- Splits each instruction into ALU opcode and 8-bit operand and issues it to the ALU with a valid/ready handshake.
- Emits a one-cycle step pulse that drives the counter's count input to advance to the next instruction.

Parameters:
- width, 4, address width; must match the counter's width. Memory depth is 2**width words.
- iw, 12, instruction word width. Bits [11:8] are the opcode; bits [7:0] are the operand.

Ports:
- count  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_addr  input  width  current address from the counter.
- run  input  1  level; 1 = execute program.
- prog_we  input  1  program-memory write enable.
- prog_addr  input  width  program-memory write address.
- prog_data  input  iw  program-memory write data.
- alu_ready  input  1  ALU accepts the issued op when high with op_valid.
- alu_op  output  4  opcode of the issued instruction.
- alu_operand  output  8  operand of the issued instruction.
- op_valid  output  1  issued op is valid.
- pc_step  output  1  one-cycle pulse; drives the counter's count input.
- halted  output  1  HALT instruction reached.
- issued_cnt  output  8  number of completed handshakes.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE.
  - alu_op=0, alu_operand=0, op_valid=0, pc_step=0, halted=0, issued_cnt=0, internal instruction register=0.
  - Program memory is NOT cleared.
- Reset mid-operation aborts immediately; any in-flight op is dropped with no handshake counted.
- States: IDLE, FETCH, ISSUE, STEP, HALT. All outputs are registered.
- IDLE:
  - run=1 -> FETCH on the next edge.
  - Otherwise remain in IDLE.
- FETCH (1 cycle):
  - Latch mem[pc_addr] into the instruction register.
  - Drive alu_op = instr[11:8] and alu_operand = instr[7:0], both valid from the next cycle.
  - Opcode 4'hF -> HALT.
  - Opcode 4'h0 (NOP) -> STEP, with no issue and no count.
  - Any other opcode -> ISSUE, with op_valid=1.
- ISSUE:
  - op_valid=1. alu_op and alu_operand are held stable until the handshake.
  - Handshake occurs on the first edge where op_valid=1 and alu_ready=1.
  - At the handshake: op_valid->0, issued_cnt increments (modulo 256, so 255->0), pc_step->1, state->STEP.
  - alu_ready high at the first ISSUE cycle gives a 1-cycle issue.
- STEP (1 cycle):
  - pc_step=1 for exactly this cycle; it falls at the next edge.
  - The counter advances within this cycle, so pc_addr is valid by the next FETCH.
  - run=1 -> FETCH; run=0 -> IDLE.
- run drop: run deasserting during FETCH or ISSUE does not abort. The in-flight instruction completes its handshake and step, then the block goes to IDLE.
- HALT:
  - halted=1, op_valid=0, pc_step never pulses.
  - Exit only by reset.
- Fetch-to-issue latency: op_valid rises 1 cycle after entering FETCH. Minimum instruction period is 3 cycles (FETCH, ISSUE, STEP).
- Address wrap: the block does no wrap logic of its own; wrap-around is the counter's modulo 2**width arithmetic, and fetch follows pc_addr.
- Program writes:
  - Accepted only in IDLE or HALT; ignored in FETCH, ISSUE and STEP.
  - A write takes effect on the edge.
  - A write to the address being fetched in the same cycle is impossible, because writes are blocked in FETCH.

Test Plan:
- Load mem[0]=12'h305 and mem[1]=12'hF00, with pc_addr held by the counter model at reset value 0 and offset 1; assert run with alu_ready=1.
  - Expect op_valid=1 with alu_op=3 and alu_operand=8'h05 for 1 cycle, then pc_step pulse, issued_cnt=1.
  - Then halted=1 with no further pc_step.
- Backpressure: alu_ready=0 for 4 cycles during ISSUE.
  - Expect op_valid, alu_op and alu_operand stable for 5 cycles, exactly 1 handshake, issued_cnt +1.
- NOP: mem[0]=12'h0AA.
  - Expect pc_step with op_valid never asserted and issued_cnt unchanged.
- Drop run during ISSUE.
  - Expect the handshake to still complete, one pc_step, then IDLE with op_valid=0.
- Assert reset low mid-ISSUE.
  - Expect all outputs 0 immediately, before the next clock edge.
  - Program memory contents intact: re-run fetches the same instruction.
- Issue 256 non-NOP ops (width=8 counter).
  - Expect issued_cnt to wrap to 0.
- prog_we pulsed during FETCH.
  - Expect the write ignored; the memory read-back value is unchanged.
